// File: rtl/rvmem_pkg.sv
// rvmem_pkg: shared definitions for the multi-port RV32I block memory.
//   - clog2 helper used for address-field sizing
//   - write channel FSM state encoding
//   - legal range of the read pipeline depth
package rvmem_pkg;

  localparam int RD_DELAY_MIN = 1;
  localparam int RD_DELAY_MAX = 4;
  localparam int RD_PORTS_MIN = 1;
  localparam int RD_PORTS_MAX = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input longint unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rvmem_rdport.sv
// rvmem_rdport: one independent read channel of rvmem_mp.
//   clock, reset        : clock and asynchronous active-high reset
//   live                : high from the first edge after reset release
//   raen / rardy        : request / ready; request accepted when both high
//   mem_word            : array word at this port's address (combinational)
//   fwd_hit/data/mask   : same-edge write commit to this word (merged in)
//   rdata / rdrdy       : read data (held until next completion) / valid pulse
// The request is sampled on the acceptance edge and travels down a
// READ_DELAY-deep valid/data pipeline; the last stage is the output register.
module rvmem_rdport
  import rvmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int READ_DELAY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  live,
  input  logic                  raen,
  output logic                  rardy,
  input  logic [DATA_WIDTH-1:0] mem_word,
  input  logic                  fwd_hit,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  input  logic [DATA_WIDTH/8-1:0] fwd_mask,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdrdy
);

  localparam int MW = DATA_WIDTH / 8;

  logic [READ_DELAY-1:0] vld;
  logic [DATA_WIDTH-1:0] pipe [READ_DELAY];
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept;

  // Busy from the cycle after acceptance until the completion cycle.
  assign rardy  = live & ~(|vld);
  assign accept = raen & rardy;

  always_comb begin
    merged = mem_word;
    if (fwd_hit) begin
      for (int i = 0; i < MW; i++) begin
        if (fwd_mask[i]) merged[i*8 +: 8] = fwd_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < READ_DELAY; i++) pipe[i] <= '0;
    end else begin
      vld[0] <= accept;
      if (accept) pipe[0] <= merged;
      for (int i = 1; i < READ_DELAY; i++) begin
        vld[i] <= vld[i-1];
        // Stages only load when fed, so the final stage holds its data.
        if (vld[i-1]) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rdata = pipe[READ_DELAY-1];
  assign rdrdy = vld[READ_DELAY-1];

endmodule

// File: rtl/rvmem_mp.sv
// rvmem_mp: multi-port block memory, one masked write channel plus
// READ_PORTS independent read channels with READ_DELAY-cycle latency.
//   clock, reset              : clock and asynchronous active-high reset
//   waen/waddr/wardy          : write address phase
//   wden/wdata/wmask/wdrdy    : write data phase (byte enables)
//   wbvld                     : one-cycle write response
//   raen/raddr/rardy          : per-port read request (packed, port p at [p*W +: W])
//   rdata/rdrdy               : per-port read data and one-cycle valid
// Optional macro RVMEM_WR_FWD_EN: a read accepted on the write-commit edge
// to the same word returns the merged word; otherwise it returns old data.
//
// Write FSM:
//   state  | meaning
//   W_IDLE | wardy high, waiting for a write address
//   W_DATA | address latched, wdrdy high, waiting for write data
//   W_RESP | memory updated, wbvld pulses for one cycle
module rvmem_mp
  import rvmem_pkg::*;
#(
  parameter int MEM_SIZE       = 'h100000,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MASK_WIDTH     = MEM_DATA_WIDTH / 8,
  parameter int READ_PORTS     = 2,
  parameter int READ_DELAY     = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 waen,
  input  logic [MEM_ADDR_WIDTH-1:0]            waddr,
  output logic                                 wardy,
  input  logic                                 wden,
  input  logic [MEM_DATA_WIDTH-1:0]            wdata,
  input  logic [MASK_WIDTH-1:0]                wmask,
  output logic                                 wdrdy,
  output logic                                 wbvld,
  input  logic [READ_PORTS-1:0]                raen,
  input  logic [READ_PORTS*MEM_ADDR_WIDTH-1:0] raddr,
  output logic [READ_PORTS-1:0]                rardy,
  output logic [READ_PORTS*MEM_DATA_WIDTH-1:0] rdata,
  output logic [READ_PORTS-1:0]                rdrdy
);

  localparam int ADDR_LO   = clog2(MASK_WIDTH);
  localparam int IDX_W     = clog2(MEM_SIZE / MASK_WIDTH);
  localparam int ADDR_HI   = IDX_W + ADDR_LO - 1;
  localparam int MEM_WORDS = MEM_SIZE / MASK_WIDTH;

  if (READ_DELAY < RD_DELAY_MIN || READ_DELAY > RD_DELAY_MAX) begin : g_bad_delay
    $error("rvmem_mp: READ_DELAY out of range 1..4");
  end
  if (READ_PORTS < RD_PORTS_MIN || READ_PORTS > RD_PORTS_MAX) begin : g_bad_ports
    $error("rvmem_mp: READ_PORTS out of range 1..4");
  end

  logic [MEM_DATA_WIDTH-1:0] mem [MEM_WORDS];

  wstate_e          state, next_state;
  logic             live;
  logic [IDX_W-1:0] widx_q;
  logic             commit;

  // Sub-word and above-range address bits are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{waddr, raddr};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= W_IDLE;
      live   <= 1'b0;
      widx_q <= '0;
    end else begin
      state <= next_state;
      live  <= 1'b1;
      if (wardy && waen) widx_q <= waddr[ADDR_HI:ADDR_LO];
    end
  end

  always_comb begin
    next_state = state;
    wardy      = 1'b0;
    wdrdy      = 1'b0;
    wbvld      = 1'b0;
    case (state)
      W_IDLE: begin
        wardy = live;
        if (live && waen) next_state = W_DATA;
      end
      W_DATA: begin
        wdrdy = 1'b1;
        if (wden) next_state = W_RESP;
      end
      W_RESP: begin
        wbvld      = 1'b1;
        next_state = W_IDLE;
      end
      default: next_state = W_IDLE;
    endcase
  end

  assign commit = wdrdy & wden;

  // Array is not reset; reset forces W_IDLE asynchronously so no commit occurs.
  always_ff @(posedge clock) begin
    if (commit) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wmask[i]) mem[widx_q][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [IDX_W-1:0]          ridx;
    logic [MEM_DATA_WIDTH-1:0] word;
    logic                      hit;

    assign ridx = raddr[p*MEM_ADDR_WIDTH + ADDR_LO +: IDX_W];
    assign word = mem[ridx];
`ifdef RVMEM_WR_FWD_EN
    assign hit = commit && (ridx == widx_q);
`else
    assign hit = 1'b0;
`endif

    rvmem_rdport #(
      .DATA_WIDTH (MEM_DATA_WIDTH),
      .READ_DELAY (READ_DELAY)
    ) u_rdport (
      .clock    (clock),
      .reset    (reset),
      .live     (live),
      .raen     (raen[p]),
      .rardy    (rardy[p]),
      .mem_word (word),
      .fwd_hit  (hit),
      .fwd_data (wdata),
      .fwd_mask (wmask),
      .rdata    (rdata[p*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]),
      .rdrdy    (rdrdy[p])
    );
  end

endmodule
